csram_arbiter: RTL and testbench



---
 rtl/csram_arb_pkg.sv | 23 ++
 rtl/csram_arb_if.sv | 55 +++++
 rtl/csram_arb_select.sv | 38 +++
 rtl/csram_arbiter.sv | 125 ++++++++++++
 tb/tb_csram_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/csram_arb_pkg.sv
// ============================================================================
// csram_arb_pkg : shared types and constants for the csram two-port arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package csram_arb_pkg;

  localparam int CSRAM_ADDR_W = 16;
  localparam int CSRAM_DATA_W = 16;

  localparam logic PORT_CPU    = 1'b0;
  localparam logic PORT_LOADER = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/csram_arb_if.sv
// ============================================================================
// csram_arb_if : requester ports and SRAM port of the csram arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

interface csram_arb_if
  import csram_arb_pkg::*;
  ();

  logic                    req0;
  logic                    we0;
  logic [CSRAM_ADDR_W-1:0] address0;
  logic [CSRAM_DATA_W-1:0] wdata0;
  logic                    ack0;
  logic [CSRAM_DATA_W-1:0] rdata0;

  logic                    req1;
  logic                    we1;
  logic [CSRAM_ADDR_W-1:0] address1;
  logic [CSRAM_DATA_W-1:0] wdata1;
  logic                    ack1;
  logic [CSRAM_DATA_W-1:0] rdata1;

  logic [CSRAM_ADDR_W-1:0] sram_address;
  logic [CSRAM_DATA_W-1:0] sram_data;
  logic                    sram_write_enable;
  logic                    sram_output_enable;
  logic [CSRAM_DATA_W-1:0] sram_read_data;

  logic                    busy;

  // Arbiter side
  modport slave (
    input  req0, we0, address0, wdata0,
    input  req1, we1, address1, wdata1,
    input  sram_read_data,
    output ack0, rdata0, ack1, rdata1,
    output sram_address, sram_data, sram_write_enable, sram_output_enable,
    output busy
  );

  // Requester / memory side
  modport master (
    output req0, we0, address0, wdata0,
    output req1, we1, address1, wdata1,
    output sram_read_data,
    input  ack0, rdata0, ack1, rdata1,
    input  sram_address, sram_data, sram_write_enable, sram_output_enable,
    input  busy
  );

endinterface

`default_nettype wire

// File: rtl/csram_arb_select.sv
// ============================================================================
// csram_arb_select : combinational winner pick between CPU and loader ports
// Policy macro: CSRAM_ARB_ROUND_ROBIN_EN (round robin on ties when defined)
// Revision 1.0
// ============================================================================
`default_nettype none

module csram_arb_select
  import csram_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
`ifdef CSRAM_ARB_ROUND_ROBIN_EN
  input  logic last_grant,
`endif
  output logic grant_valid,
  output logic grant_port
);

  always_comb begin
    grant_valid = req0 | req1;
    grant_port  = PORT_CPU;
`ifdef CSRAM_ARB_ROUND_ROBIN_EN
    if (req0 && req1) begin
      grant_port = ~last_grant;
    end else if (req1) begin
      grant_port = PORT_LOADER;
    end
`else
    if (!req0 && req1) begin
      grant_port = PORT_LOADER;
    end
`endif
  end

endmodule

`default_nettype wire

// File: rtl/csram_arbiter.sv
// ============================================================================
// csram_arbiter : shares one csram port between CPU (0) and loader (1)
// Optional build macro: CSRAM_ARB_ROUND_ROBIN_EN
// Revision 1.0
// ============================================================================
`default_nettype none

module csram_arbiter
  import csram_arb_pkg::*;
(
  input  wire logic     clk,
  input  wire logic     reset,
  csram_arb_if.slave    bus
);

  arb_state_t              state_q, state_d;
  logic                    grant_q, grant_d;
  logic                    we_q, we_d;
  logic [CSRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [CSRAM_DATA_W-1:0] wdata_q, wdata_d;
  logic [CSRAM_DATA_W-1:0] rdata0_q, rdata0_d;
  logic [CSRAM_DATA_W-1:0] rdata1_q, rdata1_d;

  logic sel_valid;
  logic sel_port;

`ifdef CSRAM_ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;
`endif

  csram_arb_select u_select (
    .req0        (bus.req0),
    .req1        (bus.req1),
`ifdef CSRAM_ARB_ROUND_ROBIN_EN
    .last_grant  (last_grant_q),
`endif
    .grant_valid (sel_valid),
    .grant_port  (sel_port)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef CSRAM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          state_d = ACCESS;
          grant_d = sel_port;
          we_d    = (sel_port == PORT_LOADER) ? bus.we1      : bus.we0;
          addr_d  = (sel_port == PORT_LOADER) ? bus.address1 : bus.address0;
          wdata_d = (sel_port == PORT_LOADER) ? bus.wdata1   : bus.wdata0;
`ifdef CSRAM_ARB_ROUND_ROBIN_EN
          last_grant_d = sel_port;
`endif
        end
      end
      ACCESS: begin
        // csram is combinational, so read data is valid within this cycle
        if (!we_q) begin
          if (grant_q == PORT_LOADER) begin
            rdata1_d = bus.sram_read_data;
          end else begin
            rdata0_d = bus.sram_read_data;
          end
        end
        state_d = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= PORT_CPU;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef CSRAM_ARB_ROUND_ROBIN_EN
      last_grant_q <= PORT_LOADER;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef CSRAM_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Address/data stay parked on the last latched operands; enables gate access
  assign bus.sram_address       = addr_q;
  assign bus.sram_data          = wdata_q;
  assign bus.sram_write_enable  = (state_q == ACCESS) &&  we_q;
  assign bus.sram_output_enable = (state_q == ACCESS) && !we_q;

  assign bus.ack0   = (state_q == ACK) && (grant_q == PORT_CPU);
  assign bus.ack1   = (state_q == ACK) && (grant_q == PORT_LOADER);
  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;
  assign bus.busy   = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_csram_arbiter.sv
// ============================================================================
// tb_csram_arbiter : directed vector table plus corner sequences for csram_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_csram_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  csram_arb_if bus ();

  csram_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r0;
    logic        w0;
    logic [15:0] a0;
    logic [15:0] d0;
    logic        r1;
    logic        w1;
    logic [15:0] a1;
    logic [15:0] d1;
    logic [15:0] rd;
    logic        exp_fix;
    logic        exp_rr;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drop_reqs();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic        win;
  logic        exp_we;
  logic [15:0] exp_addr;
  logic [15:0] exp_data;
  logic [15:0] exp_r0;
  logic [15:0] exp_r1;
  int          nack;
  int          last_k;
  logic        exp_port;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.address0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.address1 = '0; bus.wdata1 = '0;
    bus.sram_read_data = '0;

    //          r0 w0 a0        d0        r1 w1 a1        d1        rd        fix   rr
    vecs[0] = '{1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h1234, 1'b0, 1'b0};
    vecs[1] = '{0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0020, 16'hBEEF, 16'hDEAD, 1'b1, 1'b1};
    vecs[2] = '{0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0030, 16'h0000, 16'h5A5A, 1'b1, 1'b1};
    vecs[3] = '{1, 1, 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 16'h0000, 16'h9999, 1'b0, 1'b0};
    vecs[4] = '{1, 0, 16'h0040, 16'h0000, 1, 0, 16'h0050, 16'h0000, 16'h0F0F, 1'b0, 1'b1};
    vecs[5] = '{1, 1, 16'h0060, 16'h1111, 1, 1, 16'h0070, 16'h2222, 16'h0000, 1'b0, 1'b0};
    vecs[6] = '{0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 16'd0);
    check("rst_ack0", bus.ack0, 16'd0);
    check("rst_ack1", bus.ack1, 16'd0);
    check("rst_rdata0", bus.rdata0, 16'h0000);
    check("rst_rdata1", bus.rdata1, 16'h0000);
    check("rst_addr", bus.sram_address, 16'h0000);
    check("rst_data", bus.sram_data, 16'h0000);
    check("rst_we", bus.sram_write_enable, 16'd0);
    check("rst_oe", bus.sram_output_enable, 16'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", bus.busy, 16'd0);

    exp_r0 = 16'h0000;
    exp_r1 = 16'h0000;

    for (int i = 0; i < 7; i++) begin
      bus.req0 = vecs[i].r0; bus.we0 = vecs[i].w0;
      bus.address0 = vecs[i].a0; bus.wdata0 = vecs[i].d0;
      bus.req1 = vecs[i].r1; bus.we1 = vecs[i].w1;
      bus.address1 = vecs[i].a1; bus.wdata1 = vecs[i].d1;
      bus.sram_read_data = vecs[i].rd;
`ifdef CSRAM_ARB_ROUND_ROBIN_EN
      win = vecs[i].exp_rr;
`else
      win = vecs[i].exp_fix;
`endif
      exp_we   = win ? vecs[i].w1 : vecs[i].w0;
      exp_addr = win ? vecs[i].a1 : vecs[i].a0;
      exp_data = win ? vecs[i].d1 : vecs[i].d0;

      @(negedge clk);
      check($sformatf("v%0d_acc_busy", i), bus.busy, 16'd1);
      check($sformatf("v%0d_acc_we", i), bus.sram_write_enable, {15'd0, exp_we});
      check($sformatf("v%0d_acc_oe", i), bus.sram_output_enable, {15'd0, !exp_we});
      check($sformatf("v%0d_acc_addr", i), bus.sram_address, exp_addr);
      if (exp_we) check($sformatf("v%0d_acc_data", i), bus.sram_data, exp_data);
      check($sformatf("v%0d_acc_acks", i), {bus.ack0, bus.ack1}, 16'd0);

      @(negedge clk);
      if (!exp_we) begin
        if (win) exp_r1 = vecs[i].rd;
        else     exp_r0 = vecs[i].rd;
      end
      check($sformatf("v%0d_ack0", i), bus.ack0, {15'd0, !win});
      check($sformatf("v%0d_ack1", i), bus.ack1, {15'd0, win});
      check($sformatf("v%0d_rdata0", i), bus.rdata0, exp_r0);
      check($sformatf("v%0d_rdata1", i), bus.rdata1, exp_r1);
      check($sformatf("v%0d_ack_en", i), {bus.sram_write_enable, bus.sram_output_enable}, 16'd0);
      drop_reqs();

      @(negedge clk);
      check($sformatf("v%0d_idle_busy", i), bus.busy, 16'd0);
      check($sformatf("v%0d_idle_acks", i), {bus.ack0, bus.ack1}, 16'd0);
      check($sformatf("v%0d_idle_addr_hold", i), bus.sram_address, exp_addr);
    end

    // Both requesters held: four consecutive grants, 3-cycle spacing
    do_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.address0 = 16'h0A00;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.address1 = 16'h0B00;
    bus.sram_read_data = 16'h7777;
    nack = 0;
    last_k = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.ack0 && bus.ack1) check("tie_dual_ack", 16'd1, 16'd0);
      if (bus.ack0 || bus.ack1) begin
`ifdef CSRAM_ARB_ROUND_ROBIN_EN
        exp_port = nack[0];
`else
        exp_port = 1'b0;
`endif
        check($sformatf("tie_ack%0d_port", nack), {15'd0, bus.ack1}, {15'd0, exp_port});
        check($sformatf("tie_ack%0d_cycle", nack), 16'(k), 16'(2 + 3 * nack));
        nack++;
        last_k = k;
      end
    end
    check("tie_ack_count", 16'(nack), 16'd4);
    drop_reqs();
    repeat (2) @(negedge clk);
    check("tie_end_busy", bus.busy, 16'd0);

    // Back-to-back port 0 with new operands presented during ack
    do_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.address0 = 16'h0100;
    bus.sram_read_data = 16'h0AAA;
    @(negedge clk);
    check("b2b_acc1_addr", bus.sram_address, 16'h0100);
    @(negedge clk);
    check("b2b_ack1", bus.ack0, 16'd1);
    check("b2b_rdata_1", bus.rdata0, 16'h0AAA);
    bus.address0 = 16'h0200;
    bus.sram_read_data = 16'h0BBB;
    @(negedge clk);
    check("b2b_gap_busy", bus.busy, 16'd0);
    @(negedge clk);
    check("b2b_acc2_oe", bus.sram_output_enable, 16'd1);
    check("b2b_acc2_addr", bus.sram_address, 16'h0200);
    @(negedge clk);
    check("b2b_ack2", bus.ack0, 16'd1);
    check("b2b_rdata_2", bus.rdata0, 16'h0BBB);
    drop_reqs();
    @(negedge clk);

    // Reset during ACCESS aborts the transaction
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.address1 = 16'h0300; bus.wdata1 = 16'hCAFE;
    @(negedge clk);
    check("rstacc_we", bus.sram_write_enable, 16'd1);
    #2 reset = 1'b1;
    #1;
    check("rstacc_busy", bus.busy, 16'd0);
    check("rstacc_we_off", bus.sram_write_enable, 16'd0);
    check("rstacc_addr", bus.sram_address, 16'h0000);
    check("rstacc_data", bus.sram_data, 16'h0000);
    check("rstacc_rdata0", bus.rdata0, 16'h0000);
    drop_reqs();
    @(negedge clk);
    check("rstacc_no_ack", {bus.ack0, bus.ack1}, 16'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rstacc_no_ack2", {bus.ack0, bus.ack1}, 16'd0);
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.address1 = 16'h0301;
    bus.sram_read_data = 16'h1357;
    @(negedge clk);
    check("rstacc_fresh_oe", bus.sram_output_enable, 16'd1);
    @(negedge clk);
    check("rstacc_fresh_ack1", bus.ack1, 16'd1);
    check("rstacc_fresh_rdata1", bus.rdata1, 16'h1357);
    drop_reqs();
    @(negedge clk);

    // Port 0 pulses while port 1 is served: request is lost
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.address1 = 16'h0400;
    bus.sram_read_data = 16'h2468;
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.address0 = 16'h0500;
    @(negedge clk);
    check("lost_ack1", bus.ack1, 16'd1);
    check("lost_rdata1", bus.rdata1, 16'h2468);
    drop_reqs();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("lost_no_ack0_%0d", k), bus.ack0, 16'd0);
      check($sformatf("lost_busy_%0d", k), bus.busy, 16'd0);
    end
    check("lost_rdata0_kept", bus.rdata0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
